mem_copy_dma: RTL

- Command-driven block-copy engine; the requester sitting directly upstream of the simulation memory model's read/write request channels.
- Accepts one copy command (source address, destination address, word count).
- Splits the copy into bursts of at most MAX_BURST words.
- Each burst is fully read into an internal FIFO, then written back out from it. Used by testbenches and accelerator control as the memory-traffic front end.

---
 rtl/mem_dma_pkg.sv | 16 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/mem_copy_dma.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mem_dma_pkg.sv
// Shared definitions for the block-copy DMA engine: FSM state encoding and
// the fixed beat size code used on both request channels.
package mem_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    WR_REQ,
    WR_DATA,
    DONE
  } state_t;

  localparam logic [2:0] SIZE_WORD = 3'd2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; dout shows the head whenever
// the FIFO is not empty. DEPTH must be a power of two so pointers wrap freely.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/mem_copy_dma.sv
// Block-copy engine: splits a word-count copy into bursts of up to MAX_BURST,
// reads each burst fully into a FIFO, then writes it back out.
module mem_copy_dma
  import mem_dma_pkg::*;
#(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter int MAX_BURST  = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AXI_AWIDTH-1:0] cmd_src_addr,
  input  logic [AXI_AWIDTH-1:0] cmd_dst_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  done,
  output logic                  busy,
  output logic                  read_request_valid,
  input  logic                  read_request_ready,
  output logic [AXI_AWIDTH-1:0] read_request_addr,
  output logic [31:0]           read_len,
  output logic [2:0]            read_size,
  input  logic [AXI_DWIDTH-1:0] read_data,
  input  logic                  read_data_valid,
  output logic                  read_data_ready,
  output logic                  write_request_valid,
  input  logic                  write_request_ready,
  output logic [AXI_AWIDTH-1:0] write_request_addr,
  output logic [31:0]           write_len,
  output logic [2:0]            write_size,
  output logic [AXI_DWIDTH-1:0] write_data,
  output logic                  write_data_valid,
  input  logic                  write_data_ready
);
  localparam int                   CW    = $clog2(MAX_BURST) + 1;
  localparam logic [LEN_WIDTH-1:0] MAX_B = LEN_WIDTH'(MAX_BURST);

  state_t                state_q, state_d;
  logic [AXI_AWIDTH-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]  blen, blen_m1;
  logic [AXI_AWIDTH-1:0] step;
  logic                  last_beat;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [AXI_DWIDTH-1:0] fifo_dout;

  // rem only changes at the end of a write burst, so blen is stable per burst.
  assign blen      = (rem_q > MAX_B) ? MAX_B : rem_q;
  assign blen_m1   = blen - LEN_WIDTH'(1);
  assign last_beat = (LEN_WIDTH'(cnt_q) == blen_m1);
  assign step      = AXI_AWIDTH'(blen) << 2;

  assign busy       = (state_q != IDLE);
  assign read_size  = SIZE_WORD;
  assign write_size = SIZE_WORD;

  always_comb begin
    state_d             = state_q;
    src_d               = src_q;
    dst_d               = dst_q;
    rem_d               = rem_q;
    cnt_d               = cnt_q;
    cmd_ready           = 1'b0;
    done                = 1'b0;
    read_request_valid  = 1'b0;
    read_request_addr   = '0;
    read_len            = '0;
    read_data_ready     = 1'b0;
    write_request_valid = 1'b0;
    write_request_addr  = '0;
    write_len           = '0;
    write_data_valid    = 1'b0;
    write_data          = '0;
    fifo_push           = 1'b0;
    fifo_pop            = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          src_d   = cmd_src_addr;
          dst_d   = cmd_dst_addr;
          rem_d   = cmd_len;
          state_d = (cmd_len == '0) ? DONE : RD_REQ;
        end
      end
      RD_REQ: begin
        read_request_valid = 1'b1;
        read_request_addr  = src_q;
        read_len           = 32'(blen_m1);
        if (read_request_ready) begin
          cnt_d   = '0;
          state_d = RD_DATA;
        end
      end
      RD_DATA: begin
        read_data_ready = 1'b1;
        fifo_push       = read_data_valid;
        if (read_data_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        write_request_valid = 1'b1;
        write_request_addr  = dst_q;
        write_len           = 32'(blen_m1);
        if (write_request_ready) begin
          cnt_d   = '0;
          state_d = WR_DATA;
        end
      end
      WR_DATA: begin
        write_data_valid = !fifo_empty;
        write_data       = fifo_empty ? '0 : fifo_dout;
        fifo_pop         = !fifo_empty && write_data_ready;
        if (fifo_pop) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) begin
            src_d   = src_q + step;
            dst_d   = dst_q + step;
            rem_d   = rem_q - blen;
            state_d = (rem_q == blen) ? DONE : RD_REQ;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  sync_fifo #(
    .WIDTH(AXI_DWIDTH),
    .DEPTH(MAX_BURST)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .din  (read_data),
    .pop  (fifo_pop),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Leftover words from a previous burst would shift every following beat.
  a_fifo_empty_on_burst: assert property (@(posedge clk) disable iff (rst)
    (state_q == RD_REQ && read_request_ready) |-> fifo_empty);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    fifo_push |-> !fifo_full);

endmodule
